// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM states, command/response
// byte constants, frame bit positions and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    SEND      = 3'd2,
    ACK       = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

  // Bit-counter value seen at the fall that drives parity.
  localparam logic [3:0] BIT_PARITY = 4'd8;

  // Odd parity: the 9-bit {parity, data} word carries an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for W raw PS/2 lines. Line 0 additionally keeps one
// more history flop so a falling edge on it yields a single-cycle strobe.
// Flops reset to 1 (idle bus level) so reset never fakes an edge.
module ps2_line_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] line_i,
  output logic [W-1:0] sync_o,
  output logic         fall_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;
  logic         prev_q;

  // Shift raw lines through two flops; remember previous synced level of line 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= {W{1'b1}};
      sync_q <= {W{1'b1}};
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q[0];
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Pulls clock low for request-to-send,
// shifts a byte + odd parity + stop out on device clock falls, checks the
// device ACK and reports done / error (NACK or timeout).
// Optional macro PS2_TX_RETRY_EN: retry a failed frame up to two more times
// with the same latched byte before reporting error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_HOLD = CNT_W'(INHIBIT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_q, retry_d;
`endif

  logic [1:0] line_sync_s;
  logic       clk_fall_s;
  logic       clk_sync_s;
  logic       data_sync_s;
  logic       timeout_s;
  logic       fail_s;

  // Line 0 is the PS/2 clock (edge-detected), line 1 is data (sync only).
  ps2_line_sync #(.W(2)) u_sync (
    .clk_i  (clk),
    .rst_i  (rst),
    .line_i ({ps2_data_in, ps2_clk_in}),
    .sync_o (line_sync_s),
    .fall_o (clk_fall_s)
  );

  assign clk_sync_s  = line_sync_s[0];
  assign data_sync_s = line_sync_s[1];

  // Next-state and registered-output logic of the transmit FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    fail_s    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    timeout_s = (cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          byte_d   = tx_data;
          par_d    = odd_parity(tx_data);
          state_d  = INHIBIT;
          clk_oe_d = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
`ifdef PS2_TX_RETRY_EN
          retry_d  = 2'd0;
`endif
        end else begin
          cnt_d = cnt_q;
        end
      end

      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == INH_HOLD) begin
          // Start bit has been held with the clock low for one cycle: release clock.
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = SEND;
          cnt_d     = {CNT_W{1'b0}};
          bit_d     = 4'd0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == INH_LAST) begin
            data_oe_d = 1'b1;
          end else begin
            data_oe_d = 1'b0;
          end
        end
      end

      SEND: begin
        if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (clk_fall_s) begin
            bit_d = bit_q + 4'd1;
            if (bit_q < BIT_PARITY) begin
              data_oe_d = ~byte_q[bit_q[2:0]];
            end else if (bit_q == BIT_PARITY) begin
              data_oe_d = ~par_q;
            end else begin
              // Stop bit: release data and wait for the device ACK.
              data_oe_d = 1'b0;
              state_d   = ACK;
            end
          end else begin
            bit_d = bit_q;
          end
        end
      end

      ACK: begin
        if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (clk_fall_s) begin
            if (!data_sync_s) begin
              state_d = WAIT_IDLE;
            end else begin
              fail_s = 1'b1;
            end
          end else begin
            state_d = ACK;
          end
        end
      end

      WAIT_IDLE: begin
        if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (clk_sync_s && data_sync_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase

    // NACK and timeout share one exit path.
    if (fail_s) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d   = retry_q + 2'd1;
        state_d   = INHIBIT;
        clk_oe_d  = 1'b1;
        data_oe_d = 1'b0;
        cnt_d     = {CNT_W{1'b0}};
      end else begin
        state_d   = IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        error_d   = 1'b1;
      end
`else
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      error_d   = 1'b1;
`endif
    end else begin
      error_d = 1'b0;
    end

    // Ready only once the done/error pulse cycle has passed.
    ready_d = (state_d == IDLE) && !done_d && !error_d;
    busy_d  = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      bit_q     <= 4'd0;
      byte_q    <= 8'h00;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model (clock scaled to 80 system
// cycles per bit so a full frame fits inside the 1000-cycle timeout), a
// frame model built from byte + odd parity + stop, and a per-cycle monitor.
module tb_ps2_host_tx;

  localparam int INH = 5000;
  localparam int TO  = 1000;
  localparam int H   = 40;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_line = ~ps2_data_oe & dev_data;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: odd parity from a count of ones; frame is data LSB first, parity, stop.
  function automatic logic model_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i];
    f[8] = model_parity(b);
    f[9] = 1'b1;
    return f;
  endfunction

  // Monitor state shared with the main sequence.
  bit exp_q[$];
  bit exp_timeout = 1'b0;
  int pulses = 0;
  int phases = 0;

  // Per-cycle monitor: invariants, inhibit timing, timeout latency, outcomes.
  initial begin
    int  run = 0, rel = 0;
    bit  prev_pulse = 1'b0, prev_clk_oe = 1'b0, prev_data_oe = 1'b0, e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        run = 0; rel = 0; prev_pulse = 1'b0; prev_clk_oe = 1'b0; prev_data_oe = 1'b0;
      end else begin
        check("invariants",
              {27'd0, done && error, (done || error) && tx_ready, tx_ready && busy,
               tx_ready && (ps2_clk_oe || ps2_data_oe), (done || error) && (ps2_clk_oe || ps2_data_oe)},
              32'd0);
        if (prev_pulse) check("ready_after_pulse", {29'd0, tx_ready, done, error}, 32'd4);
        if (ps2_clk_oe) run++;
        if (ps2_clk_oe && !prev_clk_oe) phases++;
        if (ps2_data_oe && !prev_data_oe && ps2_clk_oe) check("start_bit_after_inhibit", run, INH + 1);
        if (!ps2_clk_oe && prev_clk_oe) begin
          check("clk_oe_low_len", run, INH + 1);
          rel = 0;
        end else begin
          rel++;
        end
        if (!ps2_clk_oe) run = 0;
        if (done || error) begin
          pulses++;
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, done, error}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("outcome", {30'd0, done, error}, e ? 32'd2 : 32'd1);
          end
          if (error && exp_timeout) check("timeout_latency", rel, TO);
        end
        prev_pulse   = done || error;
        prev_clk_oe  = ps2_clk_oe;
        prev_data_oe = ps2_data_oe;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit push, input bit exp_done);
    @(negedge clk);
    check("ready_before_send", {31'd0, tx_ready}, 32'd1);
    if (push) exp_q.push_back(exp_done);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", {29'd0, busy, tx_ready, ps2_clk_oe}, 32'd5);
  endtask

  task automatic wait_request(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4 * INH; c++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("request_to_send_seen", 32'd0, 32'd1);
  endtask

  // Device: clocks 11 bits, samples on rising edges, ACKs (data low) at fall 11 if asked.
  task automatic device_frame(input bit ack, output logic [9:0] bits);
    bit ok;
    bits = 10'd0;
    wait_request(ok);
    if (ok) begin
      repeat (5) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        dev_clk = 1'b1;
        if (i < 10) bits[i] = ps2_data_line;
        if (i == 9 && ack) dev_data = 1'b0;
        if (i == 10) dev_data = 1'b1;
        repeat (H) @(negedge clk);
      end
    end
  endtask

  task automatic wait_pulse(input int p0, input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (pulses > p0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("pulse_within_budget", 32'd0, 32'd1);
  endtask

  task automatic run_ok(input logic [7:0] b, input logic exp_par);
    logic [9:0] bits;
    int p0 = pulses;
    send(b, 1'b1, 1'b1);
    device_frame(1'b1, bits);
    check("frame_vs_model", {22'd0, bits}, {22'd0, model_frame(b)});
    check("parity_literal", {31'd0, bits[8]}, {31'd0, exp_par});
    wait_pulse(p0, 3000);
    repeat (3) @(negedge clk);
    check("one_done_pulse", pulses - p0, 32'd1);
  endtask

  initial begin
    logic [9:0] bits;
    int p0, ph0;
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, error}, 32'h20);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {26'd0, tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, error}, 32'h20);

    // Set-LED command: hand-derived bits 1,0,1,1,0,1,1,1 then parity 1, stop 1.
    p0 = pulses;
    send(8'hED, 1'b1, 1'b1);
    device_frame(1'b1, bits);
    check("ED_data_bits", {24'd0, bits[7:0]}, 32'hED);
    check("ED_parity_stop", {30'd0, bits[9:8]}, 32'd3);
    check("ED_frame_vs_model", {22'd0, bits}, {22'd0, model_frame(8'hED)});
    wait_pulse(p0, 3000);
    repeat (3) @(negedge clk);
    check("ED_one_done_pulse", pulses - p0, 32'd1);

    run_ok(8'h00, 1'b1);
    run_ok(8'h01, 1'b0);

    // NACK: device leaves data high at fall 11.
    p0 = pulses; ph0 = phases;
    send(8'hFF, 1'b1, 1'b0);
    for (int a = 0; a < ATTEMPTS; a++) begin
      device_frame(1'b0, bits);
      check("nack_frame_vs_model", {22'd0, bits}, {22'd0, model_frame(8'hFF)});
    end
    wait_pulse(p0, 3000);
    repeat (3) @(negedge clk);
    check("nack_one_error_pulse", pulses - p0, 32'd1);
    check("nack_inhibit_phases", phases - ph0, ATTEMPTS);
    check("nack_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

    // Timeout: device never clocks.
    p0 = pulses; ph0 = phases;
    exp_timeout = 1'b1;
    send(8'h55, 1'b1, 1'b0);
    wait_pulse(p0, ATTEMPTS * (INH + TO + 100));
    exp_timeout = 1'b0;
    repeat (3) @(negedge clk);
    check("timeout_one_error_pulse", pulses - p0, 32'd1);
    check("timeout_inhibit_phases", phases - ph0, ATTEMPTS);
    check("timeout_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

    // Reset after fall 4 of 0xA2 (bit 3 = 0, so data is being pulled low).
    begin
      bit ok;
      send(8'hA2, 1'b0, 1'b0);
      wait_request(ok);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        dev_clk = 1'b0;
        repeat (H) @(negedge clk);
        if (i < 3) begin
          dev_clk = 1'b1;
          repeat (H) @(negedge clk);
        end
      end
      check("pre_reset_data_oe", {31'd0, ps2_data_oe}, 32'd1);
      p0 = pulses;
      rst = 1'b1;
      @(negedge clk);
      check("reset_mid_frame", {28'd0, ps2_clk_oe, ps2_data_oe, tx_ready, busy}, 32'd2);
      dev_clk = 1'b1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("no_pulse_after_reset", pulses - p0, 32'd0);
    end
    run_ok(8'hF4, 1'b0);

    // tx_valid held high with changing tx_data: the accepted byte is sent once.
    p0 = pulses;
    @(negedge clk);
    check("ready_before_held", {31'd0, tx_ready}, 32'd1);
    exp_q.push_back(1'b1);
    tx_valid = 1'b1;
    tx_data  = 8'h5A;
    @(negedge clk);
    fork
      device_frame(1'b1, bits);
      begin
        for (int c = 0; c < 2 * INH; c++) begin
          if (done || error) break;
          tx_data = tx_data + 8'd37;
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
    join
    tx_valid = 1'b0;
    check("held_frame_is_accepted_byte", {22'd0, bits}, {22'd0, model_frame(8'h5A)});
    check("held_parity_literal", {31'd0, bits[8]}, 32'd1);
    repeat (20) @(negedge clk);
    check("held_single_transaction", {29'd0, busy, ps2_clk_oe, tx_ready}, 32'd1);
    check("held_one_pulse", pulses - p0, 32'd1);

    repeat (5) @(negedge clk);
    check("all_outcomes_seen", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
